fc_fold_sequencer: RTL and testbench

//  Sequencer for one folded HUB linear (FC) layer instance (e.g. FC3F4).
//  - On start: clears the accumulators.
//  - Then, for each of FOLD weight partitions: requests that partition's weight tile, loads it, and runs BDEP bitstream cycles.
//  - Finally: pulses sel to commit the result, then signals done.
//  - Sits between the layer-level scheduler (start/done) and the weight buffer (wReq/wAck).

---
 rtl/fc_ctrl_pkg.sv | 23 ++
 rtl/fold_cycle_counter.sv | 47 ++++
 rtl/fc_fold_sequencer.sv | 140 ++++++++++++++
 tb/tb_fc_fold_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// fc_ctrl_pkg
// Shared types and defaults for the folded fully-connected layer sequencers.
//   fc_state_t       : sequencer state encoding
//   FC_FOLD_DEFAULT  : default number of weight partitions per layer
//   FC_BDEP_DEFAULT  : default bitstream depth (RUN cycles per partition)
// ----------------------------------------------------------------------------
package fc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        WREQ,
        LOAD,
        RUN,
        SEL,
        DONE
    } fc_state_t;

    localparam int unsigned FC_FOLD_DEFAULT = 4;
    localparam int unsigned FC_BDEP_DEFAULT = 999;

endpackage

// File: rtl/fold_cycle_counter.sv
// ----------------------------------------------------------------------------
// fold_cycle_counter
// Counts the bitstream cycles of one partition and flags the final one.
//   clk   in  : clock
//   rst_n in  : asynchronous reset, active low
//   clr   in  : force count to 0 (wins over en)
//   en    in  : advance count by one
//   last  out : count == BDEP-1
// ----------------------------------------------------------------------------
module fold_cycle_counter #(
    parameter int unsigned BDEP = 999,
    parameter int unsigned CWID = $clog2(BDEP)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [CWID-1:0] LAST_VAL = CWID'(BDEP - 1);

    logic [CWID-1:0] count_q;
    logic [CWID-1:0] count_d;

    // Terminal value is detected by comparison, so the counter never
    // depends on natural overflow of its width.
    assign last = (count_q == LAST_VAL);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = last ? '0 : count_q + CWID'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fc_fold_sequencer.sv
// ----------------------------------------------------------------------------
// fc_fold_sequencer
// Sequencer for one folded FC layer: clear accumulators, then for every
// weight partition request/load its tile and run BDEP bitstream cycles,
// finally commit the result (sel) and report done.
//   clk   in  : clock
//   rst_n in  : asynchronous reset, active low
//   start in  : begin a layer pass (only honoured in IDLE)
//   abort in  : synchronous abort back to IDLE, beats every transition
//   wAck  in  : weight tile for `part` is available
//   busy  out : sequencer not idle
//   done  out : 1-cycle pulse, layer result valid
//   wReq  out : request weight tile `part`, held until wAck
//   load  out : 1-cycle pulse, datapath captures inputs/weights
//   clear out : 1-cycle pulse, datapath zeroes accumulators
//   sel   out : 1-cycle pulse, datapath commits result
//   part  out : current partition index 0..FOLD-1
// ----------------------------------------------------------------------------
module fc_fold_sequencer
    import fc_ctrl_pkg::*;
#(
    parameter int unsigned FOLD = FC_FOLD_DEFAULT,
    parameter int unsigned BDEP = FC_BDEP_DEFAULT,
    parameter int unsigned PWID = ($clog2(FOLD) < 2) ? 1 : $clog2(FOLD),
    parameter int unsigned CWID = $clog2(BDEP)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            wAck,
    output logic            busy,
    output logic            done,
    output logic            wReq,
    output logic            load,
    output logic            clear,
    output logic            sel,
    output logic [PWID-1:0] part
);

    localparam logic [PWID-1:0] LAST_PART = PWID'(FOLD - 1);

    fc_state_t       state_q;
    fc_state_t       state_d;
    logic [PWID-1:0] part_q;
    logic [PWID-1:0] part_d;
    logic            cnt_clr;
    logic            cnt_en;
    logic            cnt_last;

    fold_cycle_counter #(
        .BDEP (BDEP),
        .CWID (CWID)
    ) u_cycle_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .last  (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        part_d  = part_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLR;
                end
            end
            CLR: begin
                part_d  = '0;
                state_d = WREQ;
            end
            WREQ: begin
                if (wAck) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_clr = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    // With FOLD==1 part is always LAST_PART, so it never moves.
                    if (part_q == LAST_PART) begin
                        state_d = SEL;
                    end else begin
                        part_d  = part_q + PWID'(1);
                        state_d = WREQ;
                    end
                end
            end
            SEL: begin
                state_d = DONE;
            end
            DONE: begin
                part_d  = '0;
                state_d = IDLE;
            end
            default: begin
                part_d  = '0;
                state_d = IDLE;
            end
        endcase

        // Abort overrides whatever the case statement decided, including
        // a start seen in IDLE on the same cycle.
        if (abort) begin
            state_d = IDLE;
            part_d  = '0;
            cnt_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            part_q  <= '0;
        end else begin
            state_q <= state_d;
            part_q  <= part_d;
        end
    end

    // Outputs depend only on registered state, so reset clears them at once.
    assign busy  = (state_q != IDLE);
    assign clear = (state_q == CLR);
    assign wReq  = (state_q == WREQ);
    assign load  = (state_q == LOAD);
    assign sel   = (state_q == SEL);
    assign done  = (state_q == DONE);
    assign part  = part_q;

endmodule

// File: tb/tb_fc_fold_sequencer.sv
`timescale 1ns/1ps
module tb_fc_fold_sequencer;
    import fc_ctrl_pkg::*;

    localparam int A_FOLD = 4;
    localparam int A_BDEP = 8;
    localparam int A_PWID = 2;
    localparam int B_FOLD = 1;
    localparam int B_BDEP = 2;
    localparam int B_PWID = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic fin   = 1'b0;

    logic start_a = 1'b0, abort_a = 1'b0, wack_a = 1'b0;
    logic start_b = 1'b0, abort_b = 1'b0, wack_b = 1'b0;
    logic busy_a, done_a, wreq_a, load_a, clear_a, sel_a;
    logic busy_b, done_b, wreq_b, load_b, clear_b, sel_b;
    logic [A_PWID-1:0] part_a;
    logic [B_PWID-1:0] part_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fc_fold_sequencer #(.FOLD(A_FOLD), .BDEP(A_BDEP)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .wAck(wack_a),
        .busy(busy_a), .done(done_a), .wReq(wreq_a), .load(load_a),
        .clear(clear_a), .sel(sel_a), .part(part_a)
    );

    fc_fold_sequencer #(.FOLD(B_FOLD), .BDEP(B_BDEP)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .wAck(wack_b),
        .busy(busy_b), .done(done_b), .wReq(wreq_b), .load(load_b),
        .clear(clear_b), .sel(sel_b), .part(part_b)
    );

    // ------------------------------------------------------------------
    // Reference model: a layer pass is a fixed script of output vectors,
    // one per cycle, indexed from the clear cycle. Entries flagged `hold`
    // repeat until wAck is seen. pos < 0 means idle.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       wreq;
        logic       load;
        logic       clear;
        logic       sel;
        logic [7:0] part;
        logic       hold;
    } exp_t;

    function automatic int script_len(input int fold, input int bdep);
        return 3 + fold * (bdep + 2);
    endfunction

    function automatic exp_t script_at(input int fold, input int bdep, input int idx);
        exp_t e;
        int   len, k, r;
        e   = '0;
        len = script_len(fold, bdep);
        if (idx >= 0 && idx < len) begin
            e.busy = 1'b1;
            if (idx == 0) begin
                e.clear = 1'b1;
            end else if (idx == len - 1) begin
                e.done = 1'b1;
                e.part = 8'(fold - 1);
            end else if (idx == len - 2) begin
                e.sel  = 1'b1;
                e.part = 8'(fold - 1);
            end else begin
                k      = idx - 1;
                r      = k % (bdep + 2);
                e.part = 8'(k / (bdep + 2));
                if (r == 0) begin
                    e.wreq = 1'b1;
                    e.hold = 1'b1;
                end else if (r == 1) begin
                    e.load = 1'b1;
                end
            end
        end
        return e;
    endfunction

    function automatic int next_pos(input int fold, input int bdep, input int pos,
                                    input logic st, input logic ab, input logic ack);
        exp_t e;
        if (ab) return -1;
        if (pos < 0) return st ? 0 : -1;
        e = script_at(fold, bdep, pos);
        if (e.hold && !ack) return pos;
        if (pos + 1 >= script_len(fold, bdep)) return -1;
        return pos + 1;
    endfunction

    function automatic logic [13:0] vec_of(input exp_t e);
        return {e.busy, e.done, e.wreq, e.load, e.clear, e.sel, e.part};
    endfunction

    int pos_a = -1;
    int pos_b = -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_a <= -1;
            pos_b <= -1;
        end else begin
            pos_a <= next_pos(A_FOLD, A_BDEP, pos_a, start_a, abort_a, wack_a);
            pos_b <= next_pos(B_FOLD, B_BDEP, pos_b, start_b, abort_b, wack_b);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Single compare process: model pins, per-cycle comparison, invariants.
    // ------------------------------------------------------------------
    initial begin
        exp_t        e;
        exp_t        ea;
        exp_t        eb;
        logic [13:0] act_a, act_b;
        logic [3:0]  pul_a, pul_b, prev_a, prev_b;
        int          pin_load[4];
        int          nload, nbusy;
        int          dones_seen_a, dones_exp_a, dones_seen_b, dones_exp_b;

        prev_a = '0; prev_b = '0;
        dones_seen_a = 0; dones_exp_a = 0; dones_seen_b = 0; dones_exp_b = 0;

        // Hand-derived timings (cycle c <-> script index c-1).
        pin_load = '{3, 13, 23, 33};
        chk("pin_len_4x8", script_len(A_FOLD, A_BDEP), 43);
        e = script_at(A_FOLD, A_BDEP, 0);
        chk("pin_clear_c1", {31'd0, e.clear}, 1);
        for (int i = 0; i < 4; i++) begin
            e = script_at(A_FOLD, A_BDEP, pin_load[i] - 1);
            chk("pin_load", {31'd0, e.load}, 1);
            chk("pin_load_part", {24'd0, e.part}, i);
        end
        e = script_at(A_FOLD, A_BDEP, 41);
        chk("pin_sel_c42", {31'd0, e.sel}, 1);
        e = script_at(A_FOLD, A_BDEP, 42);
        chk("pin_done_c43", {31'd0, e.done}, 1);
        nload = 0; nbusy = 0;
        for (int i = 0; i < 60; i++) begin
            e = script_at(A_FOLD, A_BDEP, i);
            nload += int'(e.load);
            nbusy += int'(e.busy);
        end
        chk("pin_nload", nload, 4);
        chk("pin_nbusy", nbusy, 43);
        e = script_at(B_FOLD, B_BDEP, 2);
        chk("pin_f1_load_c3", {31'd0, e.load}, 1);
        e = script_at(B_FOLD, B_BDEP, 5);
        chk("pin_f1_sel_c6", {31'd0, e.sel}, 1);
        e = script_at(B_FOLD, B_BDEP, 6);
        chk("pin_f1_done_c7", {31'd0, e.done}, 1);

        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            ea    = script_at(A_FOLD, A_BDEP, pos_a);
            eb    = script_at(B_FOLD, B_BDEP, pos_b);
            act_a = {busy_a, done_a, wreq_a, load_a, clear_a, sel_a, 8'(part_a)};
            act_b = {busy_b, done_b, wreq_b, load_b, clear_b, sel_b, 8'(part_b)};
            chk("A_outputs", 32'(act_a), 32'(vec_of(ea)));
            chk("B_outputs", 32'(act_b), 32'(vec_of(eb)));

            if (clk == 1'b0) begin
                pul_a = {done_a, load_a, clear_a, sel_a};
                pul_b = {done_b, load_b, clear_b, sel_b};
                chk("A_pulse_excl", $countones({pul_a, wreq_a}) <= 1, 1);
                chk("B_pulse_excl", $countones({pul_b, wreq_b}) <= 1, 1);
                chk("A_pulse_width", {28'd0, pul_a & prev_a}, 0);
                chk("B_pulse_width", {28'd0, pul_b & prev_b}, 0);
                chk("A_part_range", int'(part_a) < A_FOLD, 1);
                chk("B_part_range", int'(part_b) < B_FOLD, 1);
                chk("A_wreq_state", !wreq_a || (dut_a.state_q == WREQ), 1);
                chk("B_wreq_state", !wreq_b || (dut_b.state_q == WREQ), 1);
                prev_a = pul_a;
                prev_b = pul_b;
                dones_seen_a += int'(done_a);
                dones_exp_a  += int'(ea.done);
                dones_seen_b += int'(done_b);
                dones_exp_b  += int'(eb.done);
            end

            if (fin) begin
                chk("A_done_count", dones_seen_a, dones_exp_a);
                chk("B_done_count", dones_seen_b, dones_exp_b);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change 2ns after each rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Plain pass on both instances, wAck tied high.
        wack_a = 1'b1; wack_b = 1'b1;
        start_a = 1'b1; start_b = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
        repeat (50) tick();

        // wAck withheld for five edges while part 2 is requested.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            wack_a = !(k >= 22 && k <= 26);
            tick();
        end
        wack_a = 1'b1;

        // Abort in RUN of part 1 at counter 3, then a fresh full pass.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            abort_a = (k == 17);
            tick();
        end
        abort_a = 1'b0;
        repeat (3) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (50) tick();

        // Starts while busy are dropped; start together with abort in IDLE too.
        start_a = 1'b1;
        tick();
        for (int k = 1; k <= 50; k++) begin
            start_a = (k == 10 || k == 30 || k == 43);
            tick();
        end
        start_a = 1'b1; abort_a = 1'b1;
        start_b = 1'b1; abort_b = 1'b1;
        tick();
        start_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;
        repeat (3) tick();

        // Asynchronous reset in the middle of RUN.
        start_a = 1'b1; start_b = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
        repeat (6) tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // Randomised traffic on both instances.
        for (int i = 0; i < 3000; i++) begin
            start_a = ($urandom_range(0, 19) == 0);
            abort_a = ($urandom_range(0, 99) == 0);
            wack_a  = 1'($urandom_range(0, 1));
            start_b = ($urandom_range(0, 9) == 0);
            abort_b = ($urandom_range(0, 99) == 0);
            wack_b  = 1'($urandom_range(0, 1));
            tick();
        end
        start_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;
        repeat (2) tick();
        fin = 1'b1;
    end

endmodule
